// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_pkg
// Description : Shared types and sizing helpers for the radix-4 Booth
//               pipeline (partial-product bank and adder-tree stages).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

    // Bank state: collecting partial products, or holding a complete set
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Radix-4 weight: slot idx carries 4^idx, i.e. a left shift of 2*idx
    function automatic int pp_shift(input int idx);
        return 2 * idx;
    endfunction

    function automatic int npp_of(input int width);
        return width / 2;
    endfunction

    function automatic int ppw_of(input int width);
        return width + 1;
    endfunction

    function automatic int outw_of(input int width);
        return 2 * width;
    endfunction

    function automatic int idxw_of(input int width);
        int c;
        c = $clog2(width / 2);
        return (c < 1) ? 1 : c;
    endfunction

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_pp_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : booth_pp_bank_if
// Description : Write-side and read-side handshake bundle of the Booth
//               partial-product bank.
//               master : partial-product producer + adder-tree consumer
//               slave  : the bank itself
// Signals     : pp_valid/pp_ready/pp_data/pp_idx/signed_mode (write port),
//               out_valid/out_ready/out_pp (set output), err (sticky flag)
// Revision    : 1.0 - initial release
// ============================================================================
interface booth_pp_bank_if
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int NPP  = npp_of(WIDTH);
    localparam int PPW  = ppw_of(WIDTH);
    localparam int OUTW = outw_of(WIDTH);
    localparam int IDXW = idxw_of(WIDTH);

    logic                  pp_valid;
    logic                  pp_ready;
    logic [PPW-1:0]        pp_data;
    logic [IDXW-1:0]       pp_idx;
    logic                  signed_mode;
    logic                  out_valid;
    logic                  out_ready;
    logic [NPP*OUTW-1:0]   out_pp;
    logic                  err;

    modport master (
        output pp_valid, pp_data, pp_idx, signed_mode, out_ready,
        input  pp_ready, out_valid, out_pp, err
    );

    modport slave (
        input  pp_valid, pp_data, pp_idx, signed_mode, out_ready,
        output pp_ready, out_valid, out_pp, err
    );

endinterface : booth_pp_bank_if
`default_nettype wire

// File: rtl/booth_pp_align.sv
`default_nettype none
// ============================================================================
// Module      : booth_pp_align
// Description : Combinational weight alignment of one raw Booth partial
//               product: extend to OUTW bits, then shift left by 2*idx.
// Ports       : pp_data     in  PPW   raw two's-complement partial product
//               idx         in  IDXW  slot index
//               signed_mode in  1     1 = sign-extend, 0 = zero-extend
//               aligned     out OUTW  weight-aligned, truncated word
// Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_align
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic [ppw_of(WIDTH)-1:0]  pp_data,
    input  wire logic [idxw_of(WIDTH)-1:0] idx,
    input  wire logic                      signed_mode,
    output logic      [outw_of(WIDTH)-1:0] aligned
);
    localparam int PPW  = ppw_of(WIDTH);
    localparam int OUTW = outw_of(WIDTH);

    logic            w_ext_bit;
    logic [OUTW-1:0] w_ext;

    assign w_ext_bit = signed_mode & pp_data[PPW-1];
    assign w_ext     = {{(OUTW-PPW){w_ext_bit}}, pp_data};
    // Shifting the extended word leaves the low 2*idx bits zero and lets
    // extension bits fill everything above PPW+2*idx; overflow is dropped.
    assign aligned   = w_ext << pp_shift(int'(idx));

endmodule : booth_pp_align
`default_nettype wire

// File: rtl/booth_pp_bank.sv
`default_nettype none
// ============================================================================
// Module      : booth_pp_bank
// Description : Radix-4 Booth partial-product register bank. Collects
//               WIDTH/2 partial products in any order, stores each one
//               weight-aligned, and presents the complete set to the adder
//               tree through a valid/ready handshake.
// Ports       : clk    in  rising-edge clock
//               clr_n  in  asynchronous active-low reset
//               flush  in  synchronous clear of bank and error flag
//               bus    slave side of booth_pp_bank_if
// Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_bank
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic       clk,
    input  wire logic       clr_n,
    input  wire logic       flush,
    booth_pp_bank_if.slave  bus
);
    localparam int NPP  = npp_of(WIDTH);
    localparam int OUTW = outw_of(WIDTH);

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [NPP-1:0]              r_fill;
    logic [NPP-1:0][OUTW-1:0]    r_slot;
    logic                        r_err;

    logic                        w_accept;
    logic                        w_idx_ok;
    logic [NPP-1:0]              w_hit;
    logic [NPP-1:0]              w_fill_upd;
    logic                        w_dup;
    logic                        w_full;
    logic                        w_err_set;
    logic [OUTW-1:0]             w_aligned;

    booth_pp_align #(
        .WIDTH (WIDTH)
    ) u_align (
        .pp_data     (bus.pp_data),
        .idx         (bus.pp_idx),
        .signed_mode (bus.signed_mode),
        .aligned     (w_aligned)
    );

    // Handshake outputs decode only the state register
    assign bus.pp_ready  = (r_state == COLLECT);
    assign bus.out_valid = (r_state == HOLD);
    assign bus.out_pp    = r_slot;
    assign bus.err       = r_err;

    assign w_accept = bus.pp_valid & (r_state == COLLECT);
    // Only reachable false when NPP is not a power of two
    assign w_idx_ok = (int'(bus.pp_idx) < NPP);

    always_comb begin
        w_hit = '0;
        for (int i = 0; i < NPP; i++) begin
            w_hit[i] = w_accept & w_idx_ok & (int'(bus.pp_idx) == i);
        end
    end

    assign w_fill_upd = r_fill | w_hit;
    assign w_dup      = |(r_fill & w_hit);
    assign w_full     = &w_fill_upd;
    assign w_err_set  = w_accept & (~w_idx_ok | w_dup);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_accept && w_full) w_state_nxt = HOLD;
            HOLD:    if (bus.out_ready)      w_state_nxt = COLLECT;
            default: w_state_nxt = COLLECT;
        endcase
        if (flush) w_state_nxt = COLLECT;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_fill <= '0;
            r_slot <= '0;
            r_err  <= 1'b0;
        end else if (flush) begin
            r_fill <= '0;
            r_slot <= '0;
            r_err  <= 1'b0;
        end else begin
            // Slot contents survive the transfer; only the bitmap restarts
            if (r_state == HOLD && bus.out_ready) begin
                r_fill <= '0;
            end else begin
                r_fill <= w_fill_upd;
            end
            for (int i = 0; i < NPP; i++) begin
                if (w_hit[i]) r_slot[i] <= w_aligned;
            end
            if (w_err_set) r_err <= 1'b1;
        end
    end

endmodule : booth_pp_bank
`default_nettype wire

// File: tb/tb_booth_pp_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_booth_pp_bank
// Description : Directed self-checking bench for booth_pp_bank, with a
//               WIDTH=8 instance and a WIDTH=6 (non power-of-two NPP) one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_booth_pp_bank;

    logic clk;
    logic clr_n;
    logic flush8;
    logic flush6;

    int n_tests;
    int n_fail;

    booth_pp_bank_if #(.WIDTH(8)) bus8 ();
    booth_pp_bank_if #(.WIDTH(6)) bus6 ();

    booth_pp_bank #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .clr_n (clr_n),
        .flush (flush8),
        .bus   (bus8.slave)
    );

    booth_pp_bank #(.WIDTH(6)) u_dut6 (
        .clk   (clk),
        .clr_n (clr_n),
        .flush (flush6),
        .bus   (bus6.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic w8(input logic [3:0] idx, input logic [8:0] data, input logic sm);
        bus8.pp_valid    = 1'b1;
        bus8.pp_idx      = idx[1:0];
        bus8.pp_data     = data;
        bus8.signed_mode = sm;
        @(posedge clk); #1;
        bus8.pp_valid    = 1'b0;
    endtask

    task automatic w6(input logic [3:0] idx, input logic [6:0] data, input logic sm);
        bus6.pp_valid    = 1'b1;
        bus6.pp_idx      = idx[1:0];
        bus6.pp_data     = data;
        bus6.signed_mode = sm;
        @(posedge clk); #1;
        bus6.pp_valid    = 1'b0;
    endtask

    task automatic take8();
        bus8.out_ready = 1'b1;
        @(posedge clk); #1;
        bus8.out_ready = 1'b0;
    endtask

    task automatic pulse_flush8();
        flush8 = 1'b1;
        @(posedge clk); #1;
        flush8 = 1'b0;
    endtask

    logic [63:0] held;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        clr_n   = 1'b0;
        flush8  = 1'b0;
        flush6  = 1'b0;
        bus8.pp_valid = 1'b0; bus8.pp_idx = '0; bus8.pp_data = '0;
        bus8.signed_mode = 1'b0; bus8.out_ready = 1'b0;
        bus6.pp_valid = 1'b0; bus6.pp_idx = '0; bus6.pp_data = '0;
        bus6.signed_mode = 1'b0; bus6.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        check_eq("rst_err",       64'(bus8.err),       64'd0);
        check_eq("rst_out_pp",    bus8.out_pp,         64'd0);
        clr_n = 1'b1;
        @(negedge clk);
        check_eq("rst_pp_ready",  64'(bus8.pp_ready),  64'd1);

        // Signed extension of idx2 = 1FF
        w8(0, 9'h000, 1); w8(1, 9'h000, 1); w8(2, 9'h1FF, 1); w8(3, 9'h000, 1);
        @(negedge clk);
        check_eq("sgn_slot2", bus8.out_pp, 64'h0000_FFF0_0000_0000);
        take8();
        // Zero extension of the same value
        w8(0, 9'h000, 0); w8(1, 9'h000, 0); w8(2, 9'h1FF, 0); w8(3, 9'h000, 0);
        @(negedge clk);
        check_eq("uns_slot2", bus8.out_pp, 64'h0000_1FF0_0000_0000);
        take8();

        // Out-of-order set and one-cycle latency
        w8(3, 9'h101, 1); w8(1, 9'h100, 1); w8(0, 9'h0A5, 1);
        @(negedge clk);
        check_eq("ooo_valid_early", 64'(bus8.out_valid), 64'd0);
        w8(2, 9'h000, 1);
        @(negedge clk);
        check_eq("ooo_valid",    64'(bus8.out_valid), 64'd1);
        check_eq("ooo_out_pp",   bus8.out_pp,         64'hC040_0000_FC00_00A5);
        check_eq("ooo_pp_ready", 64'(bus8.pp_ready),  64'd0);

        // Back-pressure: set stays put for 5 cycles
        held = 64'hC040_0000_FC00_00A5;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_eq("hold_out_pp",   bus8.out_pp,         held);
            check_eq("hold_valid",    64'(bus8.out_valid), 64'd1);
            check_eq("hold_pp_ready", 64'(bus8.pp_ready),  64'd0);
        end
        take8();
        @(negedge clk);
        check_eq("xfer_valid",    64'(bus8.out_valid), 64'd0);
        check_eq("xfer_pp_ready", 64'(bus8.pp_ready),  64'd1);

        // Duplicate write: overwrite and sticky err
        w8(1, 9'h003, 1);
        @(negedge clk);
        check_eq("dup_err_first", 64'(bus8.err), 64'd0);
        w8(1, 9'h004, 1);
        @(negedge clk);
        check_eq("dup_err", 64'(bus8.err), 64'd1);
        w8(0, 9'h000, 1); w8(2, 9'h000, 1); w8(3, 9'h000, 1);
        @(negedge clk);
        check_eq("dup_valid",  64'(bus8.out_valid), 64'd1);
        check_eq("dup_out_pp", bus8.out_pp,         64'h0000_0000_0010_0000);
        take8();
        w8(0, 9'h001, 1); w8(1, 9'h001, 1); w8(2, 9'h001, 1); w8(3, 9'h001, 1);
        @(negedge clk);
        check_eq("err_persist", 64'(bus8.err), 64'd1);
        take8();
        pulse_flush8();
        @(negedge clk);
        check_eq("err_flushed", 64'(bus8.err), 64'd0);

        // WIDTH=6: out-of-range index dropped
        w6(0, 7'h01, 0); w6(3, 7'h7F, 0); w6(1, 7'h01, 0);
        @(negedge clk);
        check_eq("w6_err",         64'(bus6.err),       64'd1);
        check_eq("w6_no_valid",    64'(bus6.out_valid), 64'd0);
        check_eq("w6_pp_ready",    64'(bus6.pp_ready),  64'd1);
        w6(2, 7'h01, 0);
        @(negedge clk);
        check_eq("w6_valid",  64'(bus6.out_valid), 64'd1);
        check_eq("w6_out_pp", 64'(bus6.out_pp),    64'h0_1000_4001);

        // Reset mid-collection
        w8(0, 9'h011, 0); w8(1, 9'h022, 0);
        clr_n = 1'b0;
        #2;
        check_eq("midrst_out_pp", bus8.out_pp,         64'd0);
        check_eq("midrst_valid",  64'(bus8.out_valid), 64'd0);
        @(posedge clk); #1;
        clr_n = 1'b1;
        w8(0, 9'h001, 0); w8(1, 9'h002, 0); w8(2, 9'h003, 0);
        @(negedge clk);
        check_eq("midrst_early", 64'(bus8.out_valid), 64'd0);
        w8(3, 9'h004, 0);
        @(negedge clk);
        check_eq("midrst_set_valid", 64'(bus8.out_valid), 64'd1);
        check_eq("midrst_set",       bus8.out_pp,         64'h0100_0030_0008_0001);
        take8();

        // Flush together with an accept that would complete the set
        w8(0, 9'h011, 0); w8(1, 9'h011, 0); w8(2, 9'h011, 0);
        flush8 = 1'b1;
        w8(3, 9'h011, 0);
        flush8 = 1'b0;
        @(negedge clk);
        check_eq("flw_valid",    64'(bus8.out_valid), 64'd0);
        check_eq("flw_pp_ready", 64'(bus8.pp_ready),  64'd1);
        w8(3, 9'h005, 0);
        @(negedge clk);
        check_eq("flw_partial", 64'(bus8.out_valid), 64'd0);
        w8(0, 9'h005, 0); w8(1, 9'h006, 0); w8(2, 9'h007, 0);
        @(negedge clk);
        check_eq("flw_set_valid", 64'(bus8.out_valid), 64'd1);
        check_eq("flw_set",       bus8.out_pp,         64'h0140_0070_0018_0005);

        // Flush in HOLD discards the set
        pulse_flush8();
        @(negedge clk);
        check_eq("flh_valid",  64'(bus8.out_valid), 64'd0);
        check_eq("flh_out_pp", bus8.out_pp,         64'd0);
        w8(2, 9'h001, 1); w8(0, 9'h1FE, 1); w8(3, 9'h002, 1); w8(1, 9'h003, 1);
        @(negedge clk);
        check_eq("flh_set_valid", 64'(bus8.out_valid), 64'd1);
        check_eq("flh_set",       bus8.out_pp,         64'h0080_0010_000C_FFFE);
        take8();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_booth_pp_bank
`default_nettype wire
